// File: rtl/wb_regfile.sv
// wb_regfile: write-back mux, 32-entry register file with WB-to-ID bypass, retired-write counter
module wb_regfile #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          wb_wreg,
  input  logic          wb_m2reg,
  input  logic [DW-1:0] wb_mo,
  input  logic [DW-1:0] wb_alu,
  input  logic [AW-1:0] wb_rn,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic [DW-1:0] wb_data,
  output logic [CW-1:0] wb_count
);
  logic [DW-1:0] regs [2**AW];
  logic commit;
  assign wb_data = wb_m2reg ? wb_mo : wb_alu;
  assign commit = wb_wreg && (wb_rn != '0);
  // bypass is gated by clrn so reads return 0 throughout reset
  always_comb begin
    qa = !clrn || rna == '0 ? '0 : commit && wb_rn == rna ? wb_data : regs[rna];
    qb = !clrn || rnb == '0 ? '0 : commit && wb_rn == rnb ? wb_data : regs[rnb];
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
      wb_count <= '0;
    end else if (commit) begin
      regs[wb_rn] <= wb_data;
      wb_count <= wb_count + CW'(1);
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus general-purpose register file of the 5-stage pipeline; consumes the MEM/WB pipeline register outputs directly.
- Selects the write-back value (memory output or ALU result) and commits it to a 32-entry register file.
- Serves two combinational read ports to the ID stage, with same-cycle write-to-read bypass.
- Keeps a retired-write counter for debug and performance visibility.

Parameters:
DW, 32, data width of registers and write-back value
AW, 5, register address width (2^AW entries)
CW, 32, width of retired-write counter

Ports:
clk  input  1  clock, rising edge
clrn  input  1  reset, asynchronous, active-low
wb_wreg  input  1  register write enable from MEM/WB
wb_m2reg  input  1  1 = write memory data, 0 = write ALU result
wb_mo  input  DW  memory output from MEM/WB
wb_alu  input  DW  ALU result from MEM/WB
wb_rn  input  AW  destination register number
rna  input  AW  read port A address (ID stage rs)
rnb  input  AW  read port B address (ID stage rt)
qa  output  DW  read port A data
qb  output  DW  read port B data
wb_data  output  DW  selected write-back value, for forwarding
wb_count  output  CW  count of committed register writes

Behaviour:
Reset and reset values:
- Reset is clk, clrn: asynchronous, active-low.
- While clrn=0: all registers 0, wb_count 0, and writes are suppressed.
- While clrn=0, qa=qb=0 and bypass is disabled.
- wb_data stays combinational during reset.
- Reset asserted mid-operation clears the state immediately, without waiting for a clock edge.
- The first write after reset release occurs on the first rising edge with clrn=1.

Write-back mux (combinational, 0 latency):
- wb_data = wb_m2reg ? wb_mo : wb_alu.

Commit condition:
- commit = wb_wreg && (wb_rn != 0).
- On a rising clk edge with commit: regs[wb_rn] <= wb_data.
- Register 0 is hardwired to 0 and is never written. A write to r0 is silently dropped.

Read ports (combinational):
- qa = 0 if rna = 0.
- Otherwise, if commit && wb_rn = rna: qa = wb_data (bypass).
- Otherwise qa = regs[rna].
- qb follows the same rules using rnb.
- Bypass ensures that an instruction in ID reading a register being written in WB in the same cycle sees the new value.
- Both ports may address the same register, including the one being written; both then return the bypassed value.

Counter:
- On a rising edge with commit: wb_count <= wb_count + 1.
- Wraps from 2^CW-1 to 0 with no saturation or flag.
- A write to r0 or a cycle with wb_wreg=0 does not count.

Timing and width rules:
- Write latency is 1 edge; read latency is 0.
- All arithmetic is unsigned, modulo 2^CW.
- There are no X outputs after reset.

Test Plan:
- Reset: assert clrn=0 mid-run after writing r5=0x1234 -> qa (rna=5)=0 and wb_count=0 immediately, without waiting for a clk edge. After release, r5 still reads 0.
- Write/read: wb_wreg=1, wb_m2reg=0, wb_alu=0xDEADBEEF, wb_rn=3, one edge. Then wb_wreg=0, rna=3 -> qa=0xDEADBEEF, wb_count=1.
- Mux plus bypass: wb_wreg=1, wb_m2reg=1, wb_mo=0xA5A5A5A5, wb_alu=0x1, wb_rn=7, rna=rnb=7, before the edge -> qa=qb=wb_data=0xA5A5A5A5 combinationally. After the edge, r7 holds 0xA5A5A5A5.
- r0 protection: wb_wreg=1, wb_rn=0, wb_alu=0xFFFFFFFF, one edge -> qa (rna=0)=0 both before and after the edge; wb_count unchanged; no bypass.
- Disabled write: wb_wreg=0, wb_rn=9, wb_alu=0x55 over 3 edges -> r9 keeps its prior value 0; qa (rna=9)=0; wb_count unchanged.
- Counter wrap: with CW=4, perform 17 commits to r1..r31 in rotation -> wb_count sequence reaches 15, then 0, ending at 1. Every written register reads back its last value.
